// File: rtl/soc_pwr_seq.sv
// soc_pwr_seq: walks a mask of power domains one at a time, issuing on/off/retention
// requests and waiting for each ack. Ack timeout and error reporting exist only with PWR_SEQ_TIMEOUT_EN.
module soc_pwr_seq #(
    parameter int NUM_PD         = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [NUM_PD-1:0] cmd_mask,
    output logic [NUM_PD-1:0] pwr_on_req,
    output logic [NUM_PD-1:0] pwr_off_req,
    output logic [NUM_PD-1:0] retention_req,
    input  logic [NUM_PD-1:0] pwr_on_ack,
    input  logic [NUM_PD-1:0] pwr_off_ack,
    input  logic [NUM_PD-1:0] retention_ack,
    output logic              busy,
    output logic              done_pulse,
    output logic              err,
    output logic [3:0]        err_dom,
    input  logic              err_clr
);
    localparam int CUR_W = (NUM_PD > 1) ? $clog2(NUM_PD) : 1;
    localparam logic [1:0] OP_ON        = 2'b00;
    localparam logic [1:0] OP_OFF       = 2'b01;
    localparam logic [1:0] OP_RET_ENTER = 2'b10;
    localparam logic [1:0] OP_RET_EXIT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCAN     = 3'd1,
        S_REQ      = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [NUM_PD-1:0] pending_q, pending_d;
    logic [NUM_PD-1:0] on_req_q, on_req_d;
    logic [NUM_PD-1:0] off_req_q, off_req_d;
    logic [NUM_PD-1:0] ret_hold_q, ret_hold_d;
    logic [CUR_W-1:0]  cur_q, cur_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CUR_W-1:0]  sel_s;
    logic              skip_s;
    logic              ack_s;
`ifdef PWR_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]       timer_q, timer_d;
    logic              err_q, err_d;
    logic [3:0]        err_dom_q, err_dom_d;
    logic [NUM_PD-1:0] ret_snap_q, ret_snap_d;
`endif

    function automatic logic [CUR_W-1:0] lowest_set(input logic [NUM_PD-1:0] v);
        logic [CUR_W-1:0] idx;
        idx = '0;
        for (int i = NUM_PD - 1; i >= 0; i--) begin
            if (v[i]) idx = CUR_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [CUR_W-1:0] highest_set(input logic [NUM_PD-1:0] v);
        logic [CUR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PD; i++) begin
            if (v[i]) idx = CUR_W'(i);
        end
        return idx;
    endfunction

    // Pick the next domain and decide whether it is already in the target state / acked.
    always_comb begin
        sel_s = (op_q == OP_ON || op_q == OP_RET_EXIT) ? lowest_set(pending_q) : highest_set(pending_q);
        case (op_q)
            OP_ON: begin
                skip_s = pwr_on_ack[sel_s];
                ack_s  = pwr_on_ack[cur_q];
            end
            OP_OFF: begin
                skip_s = !pwr_on_ack[sel_s] && !retention_ack[sel_s];
                ack_s  = pwr_off_ack[cur_q];
            end
            OP_RET_ENTER: begin
                skip_s = retention_ack[sel_s];
                ack_s  = retention_ack[cur_q];
            end
            OP_RET_EXIT: begin
                skip_s = !ret_hold_q[sel_s];
                ack_s  = !retention_ack[cur_q];
            end
            default: begin
                skip_s = 1'b0;
                ack_s  = 1'b0;
            end
        endcase
    end

    // Next-state logic for the sequencer and all of its registered outputs.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pending_d   = pending_q;
        on_req_d    = on_req_q;
        off_req_d   = off_req_q;
        ret_hold_d  = ret_hold_q;
        cur_d       = cur_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef PWR_SEQ_TIMEOUT_EN
        timer_d     = 16'd0;
        err_d       = err_q;
        err_dom_d   = err_dom_q;
        ret_snap_d  = ret_snap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pending_d    = cmd_mask;
                    pending_d[0] = 1'b0;
                    op_d         = cmd_op;
                    state_d      = S_SCAN;
                    cmd_ready_d  = 1'b0;
                    busy_d       = 1'b1;
`ifdef PWR_SEQ_TIMEOUT_EN
                    ret_snap_d   = ret_hold_q;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (pending_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (skip_s) begin
                    pending_d[sel_s] = 1'b0;
                end else begin
                    cur_d   = sel_s;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                case (op_q)
                    OP_ON:        on_req_d[cur_q]   = 1'b1;
                    OP_OFF:       off_req_d[cur_q]  = 1'b1;
                    OP_RET_ENTER: ret_hold_d[cur_q] = 1'b1;
                    OP_RET_EXIT:  ret_hold_d[cur_q] = 1'b0;
                    default:      on_req_d          = '0;
                endcase
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack_s) begin
                    on_req_d         = '0;
                    off_req_d        = '0;
                    pending_d[cur_q] = 1'b0;
                    state_d          = S_SCAN;
                    if (op_q == OP_OFF) begin
                        ret_hold_d[cur_q] = 1'b0;
                    end else begin
                        ret_hold_d[cur_q] = ret_hold_q[cur_q];
                    end
                end
`ifdef PWR_SEQ_TIMEOUT_EN
                else if (timer_q == TMO_LAST) begin
                    // Abandon the rest of the command and undo this domain's retention change.
                    on_req_d          = '0;
                    off_req_d         = '0;
                    pending_d         = '0;
                    ret_hold_d[cur_q] = ret_snap_q[cur_q];
                    err_d             = 1'b1;
                    err_dom_d         = 4'(cur_q);
                    state_d           = S_ERR;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
`else
                else begin
                    state_d = S_WAIT_ACK;
                end
`endif
            end
            S_DONE: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            S_ERR: begin
                if (err_clr) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
`ifdef PWR_SEQ_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end else begin
                    state_d = S_ERR;
                end
            end
            default: begin
                state_d     = S_IDLE;
                on_req_d    = '0;
                off_req_d   = '0;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            pending_q   <= '0;
            on_req_q    <= '0;
            off_req_q   <= '0;
            ret_hold_q  <= '0;
            cur_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PWR_SEQ_TIMEOUT_EN
            timer_q     <= 16'd0;
            err_q       <= 1'b0;
            err_dom_q   <= 4'd0;
            ret_snap_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            pending_q   <= pending_d;
            on_req_q    <= on_req_d;
            off_req_q   <= off_req_d;
            ret_hold_q  <= ret_hold_d;
            cur_q       <= cur_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PWR_SEQ_TIMEOUT_EN
            timer_q     <= timer_d;
            err_q       <= err_d;
            err_dom_q   <= err_dom_d;
            ret_snap_q  <= ret_snap_d;
`endif
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign pwr_on_req    = on_req_q;
    assign pwr_off_req   = off_req_q;
    assign retention_req = ret_hold_q;
    assign busy          = busy_q;
    assign done_pulse    = done_q;
`ifdef PWR_SEQ_TIMEOUT_EN
    assign err           = err_q;
    assign err_dom       = err_dom_q;
`else
    assign err           = 1'b0;
    assign err_dom       = 4'd0;
`endif
endmodule

// File: tb/tb_soc_pwr_seq.sv
// Scoreboard bench for soc_pwr_seq: a behavioural power-domain controller answers the
// requests, expected request order is queued per command and popped as requests appear.
module tb_soc_pwr_seq;
    localparam int NPD = 12;
    localparam int TMO = 16;
`ifdef PWR_SEQ_TIMEOUT_EN
    localparam int LONG_DLY = 10;
`else
    localparam int LONG_DLY = 256;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [NPD-1:0] cmd_mask;
    logic [NPD-1:0] pwr_on_req, pwr_off_req, retention_req;
    logic [NPD-1:0] pwr_on_ack, pwr_off_ack, retention_ack;
    logic           busy, done_pulse, err;
    logic [3:0]     err_dom;
    logic           err_clr;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [NPD-1:0] exp_hold;
    int             exp_q[$];

    soc_pwr_seq #(.NUM_PD(NPD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask),
        .pwr_on_req(pwr_on_req), .pwr_off_req(pwr_off_req), .retention_req(retention_req),
        .pwr_on_ack(pwr_on_ack), .pwr_off_ack(pwr_off_ack), .retention_ack(retention_ack),
        .busy(busy), .done_pulse(done_pulse), .err(err), .err_dom(err_dom), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Expected request order from the controller model's current state.
    task automatic build_exp(input logic [1:0] op, input logic [NPD-1:0] mask, output int nskip);
        int   d;
        logic skip;
        exp_q.delete();
        nskip = 0;
        for (int k = 1; k < NPD; k++) begin
            d = (op == 2'b00 || op == 2'b11) ? k : NPD - k;
            if (mask[d]) begin
                case (op)
                    2'b00:   skip = pwr_on_ack[d];
                    2'b01:   skip = !pwr_on_ack[d] && !retention_ack[d];
                    2'b10:   skip = retention_ack[d];
                    default: skip = !exp_hold[d];
                endcase
                if (skip) nskip++;
                else exp_q.push_back(d);
            end
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [NPD-1:0] mask);
        int w;
        cmd_op = op;
        cmd_mask = mask;
        cmd_valid = 1'b1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready got %b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Answers requests after dly cycles and checks them against the queue until done_pulse.
    task automatic service(input logic [1:0] op, input int dly, input int exp_done_cyc);
        logic [NPD-1:0] prev_on, prev_off, prev_ret, rise;
        int   cyc, d, e, pend_dom, pend_cnt, drop_dom;
        logic fin, overlap, wrong, hs_bad, err_seen;
        prev_on = '0; prev_off = '0; prev_ret = exp_hold;
        cyc = 1; fin = 1'b0; overlap = 1'b0; wrong = 1'b0; hs_bad = 1'b0; err_seen = 1'b0;
        pend_dom = -1; pend_cnt = 0; drop_dom = -1;
        while (!fin && cyc < 3000) begin
            pwr_off_ack = '0;
            if ($countones(pwr_on_req | pwr_off_req) > 1) overlap = 1'b1;
            if ((op == 2'b00 && pwr_off_req != '0) || (op == 2'b01 && pwr_on_req != '0) ||
                (op[1] && (pwr_on_req | pwr_off_req) != '0)) wrong = 1'b1;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
            if (err !== 1'b0) err_seen = 1'b1;
            if (drop_dom >= 0) begin
                n_checks++;
                if (pwr_on_req[drop_dom] !== 1'b0 || pwr_off_req[drop_dom] !== 1'b0 ||
                    retention_req[drop_dom] !== exp_hold[drop_dom]) begin
                    n_fail++;
                    $display("FAIL req_drop dom %0d: on %b off %b ret %b want 0 0 %b", drop_dom,
                             pwr_on_req[drop_dom], pwr_off_req[drop_dom], retention_req[drop_dom], exp_hold[drop_dom]);
                end
                drop_dom = -1;
            end
            case (op)
                2'b00:   rise = pwr_on_req & ~prev_on;
                2'b01:   rise = pwr_off_req & ~prev_off;
                2'b10:   rise = retention_req & ~prev_ret;
                default: rise = prev_ret & ~retention_req;
            endcase
            if (rise != '0) begin
                d = 0;
                for (int i = NPD - 1; i >= 0; i--) if (rise[i]) d = i;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL req_order: got unexpected request dom %0d want none", d);
                end else begin
                    e = exp_q.pop_front();
                    if (d != e) begin
                        n_fail++;
                        $display("FAIL req_order: got dom %0d want dom %0d", d, e);
                    end
                end
                if (op == 2'b10) exp_hold[d] = 1'b1;
                if (op == 2'b11) exp_hold[d] = 1'b0;
                pend_dom = d;
                pend_cnt = dly;
            end
            if (pend_dom >= 0) begin
                if (pend_cnt == 0) begin
                    n_checks++;
                    if ((op == 2'b00 && pwr_on_req[pend_dom] !== 1'b1) ||
                        (op == 2'b01 && pwr_off_req[pend_dom] !== 1'b1) ||
                        retention_req[pend_dom] !== exp_hold[pend_dom]) begin
                        n_fail++;
                        $display("FAIL req_held dom %0d: on %b off %b ret %b", pend_dom,
                                 pwr_on_req[pend_dom], pwr_off_req[pend_dom], retention_req[pend_dom]);
                    end
                    case (op)
                        2'b00: pwr_on_ack[pend_dom] = 1'b1;
                        2'b01: begin
                            pwr_off_ack[pend_dom]   = 1'b1;
                            pwr_on_ack[pend_dom]    = 1'b0;
                            retention_ack[pend_dom] = 1'b0;
                            exp_hold[pend_dom]      = 1'b0;
                        end
                        2'b10:   retention_ack[pend_dom] = 1'b1;
                        default: retention_ack[pend_dom] = 1'b0;
                    endcase
                    drop_dom = pend_dom;
                    pend_dom = -1;
                end else begin
                    pend_cnt--;
                end
            end
            if (done_pulse === 1'b1) begin
                fin = 1'b1;
                n_checks++;
                if (exp_q.size() != 0 || pend_dom >= 0 || overlap || wrong || hs_bad || err_seen) begin
                    n_fail++;
                    $display("FAIL done_state: left %0d pend %0d overlap %b wrong %b hs %b err %b want 0 -1 0 0 0 0",
                             exp_q.size(), pend_dom, overlap, wrong, hs_bad, err_seen);
                end
                n_checks++;
                if (retention_req !== exp_hold) begin
                    n_fail++;
                    $display("FAIL ret_vector: got %h want %h", retention_req, exp_hold);
                end
                if (exp_done_cyc > 0) begin
                    n_checks++;
                    if (cyc != exp_done_cyc) begin
                        n_fail++;
                        $display("FAIL done_latency: got %0d want %0d", cyc, exp_done_cyc);
                    end
                end
            end else begin
                prev_on = pwr_on_req; prev_off = pwr_off_req; prev_ret = retention_req;
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done_pulse within %0d cycles", cyc);
        end
        pwr_off_ack = '0;
        @(negedge clk);
        n_checks++;
        if (done_pulse !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL back_idle: done %b busy %b ready %b want 0 0 1", done_pulse, busy, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_mask = '0; err_clr = 1'b0;
        pwr_on_ack = '0; pwr_off_ack = '0; retention_ack = '0; exp_hold = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pwr_on_req, pwr_off_req, retention_req} !== '0 || busy !== 1'b0 || done_pulse !== 1'b0 ||
            err !== 1'b0 || err_dom !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: reqs %h %h %h busy %b done %b err %b dom %0d want all 0",
                     pwr_on_req, pwr_off_req, retention_req, busy, done_pulse, err, err_dom);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: ready %b busy %b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [NPD-1:0] mask, input int dly, input logic chk_lat);
        int nskip;
        build_exp(op, mask, nskip);
        send_cmd(op, mask);
        service(op, dly, chk_lat ? 2 + nskip : -1);
    endtask

    task automatic test_back_to_back();
        int nskip;
        build_exp(2'b00, 12'h300, nskip);
        send_cmd(2'b00, 12'h300);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_mask = 12'hFFE;
        service(2'b00, 3, -1);
        build_exp(2'b01, 12'hFFE, nskip);
        send_cmd(2'b01, 12'hFFE);
        service(2'b01, 0, -1);
    endtask

`ifdef PWR_SEQ_TIMEOUT_EN
    task automatic timeout_case(input logic [1:0] op, input logic [NPD-1:0] mask, input int dom);
        int w;
        logic [NPD-1:0] hold0;
        hold0 = retention_req;
        send_cmd(op, mask);
        w = 0;
        while (pwr_on_req[dom] !== 1'b1 && retention_req[dom] === hold0[dom] && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (15) @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: err %b busy %b want 0 1", err, busy);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || err_dom !== 4'(dom) || pwr_on_req !== '0 || retention_req !== hold0 || done_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err: err %b dom %0d on %h ret %h done %b want 1 %0d 0 %h 0",
                     err, err_dom, pwr_on_req, retention_req, done_pulse, dom, hold0);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err_hold: err %b ready %b want 1 0", err, cmd_ready);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || err_dom !== 4'(dom)) begin
            n_fail++;
            $display("FAIL err_clear: err %b ready %b busy %b dom %0d want 0 1 0 %0d", err, cmd_ready, busy, err_dom, dom);
        end
    endtask

    task automatic test_timeout();
        timeout_case(2'b00, 12'h020, 5);
        timeout_case(2'b10, 12'h200, 9);
    endtask
`else
    task automatic test_timeout();
        run(2'b00, 12'h020, 60, 1'b0);
    endtask
`endif

    task automatic test_reset_mid();
        int w;
        int nskip;
        run(2'b10, 12'h100, 1, 1'b0);
        build_exp(2'b00, 12'h040, nskip);
        send_cmd(2'b00, 12'h040);
        w = 0;
        while (pwr_on_req[6] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (pwr_on_req[6] !== 1'b1 || retention_req[8] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: on_req6 %b ret8 %b want 1 1", pwr_on_req[6], retention_req[8]);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pwr_on_req, pwr_off_req, retention_req} !== '0 || busy !== 1'b0 || done_pulse !== 1'b0 ||
            err !== 1'b0 || err_dom !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset: reqs %h %h %h busy %b done %b err %b dom %0d want all 0",
                     pwr_on_req, pwr_off_req, retention_req, busy, done_pulse, err, err_dom);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || done_pulse !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: ready %b done %b busy %b want 1 0 0", cmd_ready, done_pulse, busy);
        end
    endtask

    initial begin
        test_reset();
        run(2'b00, 12'h001, 0, 1'b1);          // always-on only: nothing to do
        run(2'b00, 12'h00A, LONG_DLY, 1'b0);   // ON ascending 1 then 3
        run(2'b01, 12'h00A, 2, 1'b0);          // OFF descending 3 then 1
        run(2'b00, 12'h01E, 1, 1'b0);
        run(2'b00, 12'h00A, 0, 1'b1);          // all skipped
        run(2'b10, 12'h010, 3, 1'b0);
        run(2'b01, 12'h010, 5, 1'b0);          // retention_req[4] falls with off
        run(2'b10, 12'h060, 2, 1'b0);
        run(2'b11, 12'h0E0, 2, 1'b0);          // domain 7 skipped
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
